// File: rtl/reg_bank_arbiter.sv
// Shared register bank with a round-robin write arbiter.
// NREQ requesters compete for one write slot per cycle. The read port is
// registered, so a read always returns the value from before a write on the
// same edge. Reset clears the bank, the read/write status outputs and the
// round-robin pointer.
module reg_bank_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int NREQ      = 4,
    parameter int DEPTH     = 8,
    parameter int AW        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*AW-1:0]        wr_addr,
    input  logic [NREQ*DATAWIDTH-1:0] wr_data,
    output logic [NREQ-1:0]           gnt,
    output logic                      wr_done,
    output logic [$clog2(NREQ)-1:0]   wr_src,
    input  logic [AW-1:0]             rd_addr,
    output logic [DATAWIDTH-1:0]      rd_data
);

    localparam int SW = $clog2(NREQ);

    logic [DATAWIDTH-1:0]       bank_reg [DEPTH];
    logic [SW-1:0]              ptr_reg;
    logic [SW-1:0]              ptr_next;

    // Candidate order for this cycle: slot k holds requester (ptr + k) mod NREQ
    logic [NREQ-1:0][SW-1:0]    cand_idx;
    logic [NREQ-1:0]            cand_req;

    logic                       any_req;
    logic [SW-1:0]              sel_idx;
    logic                       grant_valid;
    logic [AW-1:0]              sel_addr;
    logic [DATAWIDTH-1:0]       sel_data;
    logic                       addr_ok;
    logic                       wr_en;

    logic [DEPTH-1:0]           wr_hit;
    logic [DEPTH-1:0]           rd_hit;
    logic [DATAWIDTH-1:0]       rd_next;

    genvar gi;

    // Rotate the request vector so that slot 0 is the current priority holder
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign cand_idx[gi] = (32'(ptr_reg) + gi >= NREQ)
                                ? SW'(32'(ptr_reg) + gi - NREQ)
                                : SW'(32'(ptr_reg) + gi);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // First asserted request in rotated order wins
    always_comb begin
        any_req = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && cand_req[k]) begin
                any_req = 1'b1;
                sel_idx = cand_idx[k];
            end
        end
    end

    // Grants are suppressed while reset is held
    assign grant_valid = rst && any_req;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = grant_valid && (sel_idx == SW'(gi));
        end
    endgenerate

    assign sel_addr = wr_addr[32'(sel_idx) * AW +: AW];
    assign sel_data = wr_data[32'(sel_idx) * DATAWIDTH +: DATAWIDTH];

    // An out-of-range address still consumes the grant but writes nothing
    assign addr_ok  = 32'(sel_addr) < DEPTH;
    assign wr_en    = grant_valid && addr_ok;

    // Priority moves just past the winner; it holds when nobody is granted
    assign ptr_next = !grant_valid              ? ptr_reg
                    : (sel_idx == SW'(NREQ - 1)) ? '0
                    : sel_idx + 1'b1;

    // Per-register write and read address decode
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign wr_hit[gi] = wr_en && (32'(sel_addr) == gi);
            assign rd_hit[gi] = (32'(rd_addr) == gi);
        end
    endgenerate

    // Read mux; addresses beyond DEPTH match nothing and read as zero
    always_comb begin
        rd_next = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (rd_hit[j]) begin
                rd_next = bank_reg[j];
            end
        end
    end

    // Register bank storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                bank_reg[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_hit[j]) begin
                    bank_reg[j] <= sel_data;
                end
            end
        end
    end

    // Round-robin pointer, write status and registered read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= '0;
            wr_done <= 1'b0;
            wr_src  <= '0;
            rd_data <= '0;
        end else begin
            ptr_reg <= ptr_next;
            wr_done <= wr_en;
            if (wr_en) begin
                wr_src <= sel_idx;
            end
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed test of reg_bank_arbiter (DEPTH=6 so that addresses 6 and 7 are
// out of range). Stimulus pushes expected grants, write retirements and
// read data into queues; a monitor on the falling edge pops and compares.
module tb_reg_bank_arbiter;

    localparam int DW    = 16;
    localparam int NREQ  = 4;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   wr_addr;
    logic [NREQ*DW-1:0]   wr_data;
    logic [NREQ-1:0]      gnt;
    logic                 wr_done;
    logic [1:0]           wr_src;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_data;

    reg_bank_arbiter #(.DATAWIDTH(DW), .NREQ(NREQ), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .wr_done (wr_done),
        .wr_src  (wr_src),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [NREQ-1:0] gnt_q [$];
    int              wr_q  [$];
    logic [DW-1:0]   rd_q  [$];
    logic [DW-1:0]   model [DEPTH];

    logic gnt_chk = 1'b0;
    logic rd_req  = 1'b0;
    logic rd_vld_d = 1'b0;

    always @(posedge clk) rd_vld_d <= rd_req;

    // Monitor: compare whatever the DUT presents this cycle against the queues
    logic [NREQ-1:0] g_exp;
    int              s_exp;
    logic [DW-1:0]   d_exp;
    always @(negedge clk) begin
        n_chk++;
        if ($countones(gnt) > 1) begin
            n_fail++;
            $display("FAIL gnt_onehot: gnt=%b has more than one bit set", gnt);
        end
        if (gnt_chk) begin
            n_chk++;
            if (gnt_q.size() == 0) begin
                n_fail++;
                $display("FAIL gnt_queue: no expected grant queued, gnt=%b", gnt);
            end else begin
                g_exp = gnt_q.pop_front();
                if (gnt !== g_exp) begin
                    n_fail++;
                    $display("FAIL gnt: got %b expected %b", gnt, g_exp);
                end else
                    $display("gnt ok: %b", gnt);
            end
        end
        if (rd_vld_d) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_queue: no expected read queued, rd_data=%h", rd_data);
            end else begin
                d_exp = rd_q.pop_front();
                if (rd_data !== d_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, d_exp);
                end else
                    $display("read ok: %h", rd_data);
            end
        end
        if (wr_done !== 1'b0) begin
            n_chk++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_done: got %b with no write expected (wr_src=%0d)", wr_done, wr_src);
            end else begin
                s_exp = wr_q.pop_front();
                if (wr_done !== 1'b1 || 32'(wr_src) != s_exp) begin
                    n_fail++;
                    $display("FAIL wr_src: got done=%b src=%0d expected done=1 src=%0d",
                             wr_done, wr_src, s_exp);
                end else
                    $display("write retired: src=%0d", wr_src);
            end
        end
    end

    // Advance one cycle and clear the per-cycle check strobes
    task automatic cyc();
        @(posedge clk);
        #1;
        gnt_chk = 1'b0;
        rd_req  = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic exp_gnt(input logic [NREQ-1:0] g);
        gnt_q.push_back(g);
        gnt_chk = 1'b1;
    endtask

    // Queue a read; must be called before exp_wr in the same cycle so that
    // a same-edge write is not yet visible
    task automatic rd(input int a);
        rd_addr = AW'(a);
        rd_req  = 1'b1;
        if (a < DEPTH) rd_q.push_back(model[a]);
        else           rd_q.push_back('0);
    endtask

    task automatic exp_wr(input int src, input int a, input logic [DW-1:0] d);
        wr_q.push_back(src);
        model[a] = d;
    endtask

    task automatic clear_model();
        for (int j = 0; j < DEPTH; j++) model[j] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        clear_model();
        repeat (3) cyc();
        rst = 1'b1;

        // Pre-reset writes leaving the pointer at 2
        set_req(0, 1, 16'h1111); set_req(1, 4, 16'h4444);
        exp_gnt(4'b0001); exp_wr(0, 1, 16'h1111);
        cyc();
        req[0] = 1'b0;
        exp_gnt(4'b0010); exp_wr(1, 4, 16'h4444);
        cyc();
        req = '0;

        // Test 1: reset held two cycles with everyone requesting
        rst = 1'b0; req = 4'b1111;
        exp_gnt(4'b0000);
        cyc();
        exp_gnt(4'b0000);
        cyc();
        rst = 1'b1; req = '0;
        clear_model();
        for (int a = 0; a < 8; a++) begin
            rd(a);
            cyc();
        end

        // Test 2: all four requesting, held; pointer restarts at 0
        for (int i = 0; i < NREQ; i++) set_req(i, (i == 3) ? 4 : i, 16'h1000 + 16'(i));
        exp_gnt(4'b0001); exp_wr(0, 0, 16'h1000); cyc();
        exp_gnt(4'b0010); exp_wr(1, 1, 16'h1001); cyc();
        exp_gnt(4'b0100); exp_wr(2, 2, 16'h1002); cyc();
        exp_gnt(4'b1000); exp_wr(3, 4, 16'h1003); cyc();
        exp_gnt(4'b0001); exp_wr(0, 0, 16'h1000); cyc();
        req = '0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            cyc();
        end

        // Test 3: lone requester 2 writes BEEF to 5; same-edge read sees old
        set_req(2, 5, 16'hBEEF);
        exp_gnt(4'b0100);
        rd(5);
        exp_wr(2, 5, 16'hBEEF);
        cyc();
        req = '0;
        rd(5);
        cyc();

        // Test 4: write 1234 to address 3 while reading address 3
        set_req(0, 3, 16'h1234);
        exp_gnt(4'b0001);
        rd(3);
        exp_wr(0, 3, 16'h1234);
        cyc();
        req = '0;
        rd(3);
        cyc();

        // Test 5: out-of-range write from requester 1 (pointer 1 -> 2)
        set_req(1, 7, 16'h7777);
        exp_gnt(4'b0010);
        cyc();
        // Pointer must now be 2: requester 0 wins over requester 1
        set_req(0, 0, 16'h5555);
        exp_gnt(4'b0001);
        exp_wr(0, 0, 16'h5555);
        cyc();
        req = '0;
        rd(7); cyc();
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            cyc();
        end

        // Test 6: reset in the cycle requester 0 would be granted (pointer 1)
        set_req(0, 2, 16'hAAAA);
        rst = 1'b0;
        exp_gnt(4'b0000);
        cyc();
        rst = 1'b1; req = '0;
        clear_model();
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            cyc();
        end
        // Pointer back at 0: requester 0 beats requester 3
        set_req(0, 1, 16'h0BAD); set_req(3, 2, 16'h0DAD);
        exp_gnt(4'b0001);
        exp_wr(0, 1, 16'h0BAD);
        cyc();
        req = '0;
        rd(1);
        cyc();
        repeat (3) cyc();

        // Everything queued must have been consumed
        n_chk++;
        if (gnt_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: leftover gnt=%0d wr=%0d rd=%0d expected 0 0 0",
                     gnt_q.size(), wr_q.size(), rd_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
